// File: rtl/keypad_scan_debounce.sv
// 4x4 matrix keypad scanner: one-hot row drive, 2-flop column synchroniser, tick-based
// press/release debounce, and a registered key code with a single-cycle strobe per press.
module keypad_scan_debounce #(
  parameter int unsigned SCAN_DIV   = 50000,
  parameter int unsigned DEBOUNCE_N = 20
) (
  input  logic       clk,
  input  logic       btnres,
  input  logic [3:0] col,
  output logic [3:0] fil,
  output logic [3:0] tecla,
  output logic       key_valid,
  output logic       key_held
);

  localparam int unsigned TW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_DIV - 1);
  localparam logic [7:0] CNT_DONE = 8'(DEBOUNCE_N);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2
  } state_t;

  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'b0001)) == 4'b0000);
  endfunction

  function automatic logic [3:0] key_code(input logic [1:0] row, input logic [3:0] col_oh);
    logic [1:0] ci;
    case (col_oh)
      4'b0001: ci = 2'd0;
      4'b0010: ci = 2'd1;
      4'b0100: ci = 2'd2;
      4'b1000: ci = 2'd3;
      default: ci = 2'd0;
    endcase
    case ({row, ci})
      4'b00_00: key_code = 4'd1;
      4'b00_01: key_code = 4'd2;
      4'b00_10: key_code = 4'd3;
      4'b00_11: key_code = 4'd10;
      4'b01_00: key_code = 4'd4;
      4'b01_01: key_code = 4'd5;
      4'b01_10: key_code = 4'd6;
      4'b01_11: key_code = 4'd11;
      4'b10_00: key_code = 4'd7;
      4'b10_01: key_code = 4'd8;
      4'b10_10: key_code = 4'd9;
      4'b10_11: key_code = 4'd12;
      4'b11_00: key_code = 4'd14;
      4'b11_01: key_code = 4'd0;
      4'b11_10: key_code = 4'd15;
      4'b11_11: key_code = 4'd13;
      default:  key_code = 4'd0;
    endcase
  endfunction

  logic [3:0]    col_meta_r, col_sync_r, col_lat_r;
  logic [TW-1:0] tick_cnt_r;
  logic          tick_s;
  state_t        state_r, state_nxt_s;
  logic [1:0]    row_r, row_nxt_s;
  logic [7:0]    cnt_r, cnt_nxt_s, cnt_inc_s;
  logic [3:0]    col_lat_nxt_s, fil_nxt_s, tecla_nxt_s;
  logic          valid_nxt_s, held_nxt_s;

  assign tick_s    = (tick_cnt_r == TICK_LAST);
  assign cnt_inc_s = cnt_r + 8'd1;

  // Column synchroniser
  always_ff @(posedge clk) begin
    if (btnres) begin
      col_meta_r <= 4'b0000;
      col_sync_r <= 4'b0000;
    end else begin
      col_meta_r <= col;
      col_sync_r <= col_meta_r;
    end
  end

  // Free-running scan tick divider
  always_ff @(posedge clk) begin
    if (btnres)      tick_cnt_r <= '0;
    else if (tick_s) tick_cnt_r <= '0;
    else             tick_cnt_r <= tick_cnt_r + TW'(1);
  end

  // State register
  always_ff @(posedge clk) begin
    if (btnres) state_r <= ST_SCAN;
    else        state_r <= state_nxt_s;
  end

  // Next-state logic; a mismatching debounce sample drops back to scanning without a strobe
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_SCAN: begin
        if (tick_s && is_onehot(col_sync_r)) state_nxt_s = ST_DEBOUNCE;
        else                                 state_nxt_s = ST_SCAN;
      end
      ST_DEBOUNCE: begin
        if (!tick_s)                      state_nxt_s = ST_DEBOUNCE;
        else if (col_sync_r != col_lat_r) state_nxt_s = ST_SCAN;
        else if (cnt_inc_s == CNT_DONE)   state_nxt_s = ST_HELD;
        else                              state_nxt_s = ST_DEBOUNCE;
      end
      ST_HELD: begin
        if (tick_s && (col_sync_r == 4'b0000) && (cnt_inc_s == CNT_DONE)) state_nxt_s = ST_SCAN;
        else                                                               state_nxt_s = ST_HELD;
      end
      default: state_nxt_s = ST_SCAN;
    endcase
  end

  // Datapath and output next values; row_r doubles as the latched row while fil is frozen
  always_comb begin
    fil_nxt_s     = fil;
    row_nxt_s     = row_r;
    col_lat_nxt_s = col_lat_r;
    cnt_nxt_s     = cnt_r;
    tecla_nxt_s   = tecla;
    valid_nxt_s   = 1'b0;
    held_nxt_s    = key_held;
    case (state_r)
      ST_SCAN: begin
        if (tick_s) begin
          if (is_onehot(col_sync_r)) begin
            col_lat_nxt_s = col_sync_r;
            cnt_nxt_s     = 8'd1;
          end else begin
            row_nxt_s = row_r + 2'd1;
            fil_nxt_s = {fil[2:0], fil[3]};
          end
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      ST_DEBOUNCE: begin
        if (tick_s) begin
          if (col_sync_r == col_lat_r) begin
            if (cnt_inc_s == CNT_DONE) begin
              tecla_nxt_s = key_code(row_r, col_lat_r);
              valid_nxt_s = 1'b1;
              held_nxt_s  = 1'b1;
              cnt_nxt_s   = 8'd0;
            end else begin
              cnt_nxt_s = cnt_inc_s;
            end
          end else begin
            cnt_nxt_s = 8'd0;
          end
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      ST_HELD: begin
        if (tick_s) begin
          if (col_sync_r == 4'b0000) begin
            if (cnt_inc_s == CNT_DONE) begin
              held_nxt_s = 1'b0;
              cnt_nxt_s  = 8'd0;
              row_nxt_s  = row_r + 2'd1;
              fil_nxt_s  = {fil[2:0], fil[3]};
            end else begin
              cnt_nxt_s = cnt_inc_s;
            end
          end else begin
            cnt_nxt_s = 8'd0;
          end
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      default: begin
        cnt_nxt_s = 8'd0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (btnres) begin
      fil       <= 4'b0001;
      row_r     <= 2'd0;
      col_lat_r <= 4'b0000;
      cnt_r     <= 8'd0;
      tecla     <= 4'd0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      fil       <= fil_nxt_s;
      row_r     <= row_nxt_s;
      col_lat_r <= col_lat_nxt_s;
      cnt_r     <= cnt_nxt_s;
      tecla     <= tecla_nxt_s;
      key_valid <= valid_nxt_s;
      key_held  <= held_nxt_s;
    end
  end

endmodule
